led_sweep_decoder: RTL

- Receive-side companion to the side-to-side LED sweep generator.
- Samples the generator's 8-bit one-hot LED bus and recovers the lit position and sweep direction.
- Checks every step against the expected bounce sequence, counts edge turnarounds, and flags protocol violations.
- Used in the lab3 top level and in benches as a self-checking monitor of the LED pattern.

---
 rtl/led_sweep_pkg.sv | 16 +
 rtl/onehot8_encode.sv | 26 ++
 rtl/led_sweep_decoder.sv | 119 +++++++++++
 3 files changed

// File: rtl/led_sweep_pkg.sv
// Shared types and constants for the LED sweep decoder: FSM state encoding,
// bus width and direction values.
package led_sweep_pkg;

   localparam int unsigned LED_W     = 8;
   localparam logic [2:0]  POS_MAX   = 3'd7;
   localparam logic        DIR_LEFT  = 1'b1;
   localparam logic        DIR_RIGHT = 1'b0;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACQ   = 2'd1,
      TRACK = 2'd2
   } state_t;

endpackage : led_sweep_pkg

// File: rtl/onehot8_encode.sv
// Combinational one-hot checker and binary encoder for the 8-bit LED bus.
// The index is only meaningful when is_onehot is set.
module onehot8_encode
   import led_sweep_pkg::*;
(
   input  logic [LED_W-1:0] bus,
   output logic             is_onehot,
   output logic [2:0]       idx
);

   logic [3:0] ones;

   always_comb begin
      // NOTE: every variable gets a default first so no path can infer a latch.
      ones = 4'd0;
      idx  = 3'd0;
      for (int i = 0; i < LED_W; i++) begin
         if (bus[i]) begin
            ones = ones + 4'd1;
            idx  = idx | 3'(i);
         end
      end
      is_onehot = (ones == 4'd1);
   end

endmodule : onehot8_encode

// File: rtl/led_sweep_decoder.sv
// Monitors a bouncing one-hot LED bus: acquires lock, tracks position and
// direction, counts edge turnarounds and flags steps that break the sequence.
module led_sweep_decoder
   import led_sweep_pkg::*;
#(
   parameter int CNT_W = 8,
   parameter int ERR_W = 4
)
(
   input  logic             clk,
   input  logic             reset,
   input  logic             led_valid,
   input  logic [LED_W-1:0] led,
   output logic [2:0]       pos,
   output logic             dir,
   output logic             locked,
   output logic             err_pulse,
   output logic [ERR_W-1:0] err_cnt,
   output logic [CNT_W-1:0] bounce_cnt
);

   state_t           state;
   logic [LED_W-1:0] led_q;
   logic             is_onehot;
   logic [2:0]       idx;
   logic             adjacent;
   logic             step_ok;

   onehot8_encode u_enc (
      .bus       (led),
      .is_onehot (is_onehot),
      .idx       (idx)
   );

   // Widened compare so 7 and 0 are never treated as neighbours.
   assign adjacent = ({1'b0, idx} == ({1'b0, pos} + 4'd1)) ||
                     (({1'b0, idx} + 4'd1) == {1'b0, pos});

   assign step_ok = is_onehot &&
                    (((dir == DIR_LEFT)  && (pos != POS_MAX) && (idx == pos + 3'd1)) ||
                     ((dir == DIR_RIGHT) && (pos != 3'd0)    && (idx == pos - 3'd1)));

   // NOTE: all state uses non-blocking assignments so every register samples
   // the pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         led_q      <= '0;
         pos        <= 3'd0;
         dir        <= DIR_LEFT;
         locked     <= 1'b0;
         err_pulse  <= 1'b0;
         err_cnt    <= '0;
         bounce_cnt <= '0;
      end else begin
         err_pulse <= 1'b0;
         // A repeat of the last accepted sample is a slow generator holding still.
         if (led_valid && (led != led_q)) begin
            case (state)
               IDLE: begin
                  if (is_onehot) begin
                     led_q <= led;
                     pos   <= idx;
                     state <= ACQ;
                  end
               end
               ACQ: begin
                  if (!is_onehot) begin
                     led_q <= '0;
                     state <= IDLE;
                  end else if (adjacent) begin
                     led_q  <= led;
                     pos    <= idx;
                     locked <= 1'b1;
                     state  <= TRACK;
                     if (idx == POS_MAX) begin
                        dir        <= DIR_RIGHT;
                        bounce_cnt <= bounce_cnt + 1'b1;
                     end else if (idx == 3'd0) begin
                        dir        <= DIR_LEFT;
                        bounce_cnt <= bounce_cnt + 1'b1;
                     end else begin
                        dir <= (idx > pos) ? DIR_LEFT : DIR_RIGHT;
                     end
                  end else begin
                     led_q <= led;
                     pos   <= idx;
                  end
               end
               TRACK: begin
                  if (step_ok) begin
                     led_q <= led;
                     pos   <= idx;
                     if ((dir == DIR_LEFT) && (idx == POS_MAX)) begin
                        dir        <= DIR_RIGHT;
                        bounce_cnt <= bounce_cnt + 1'b1;
                     end else if ((dir == DIR_RIGHT) && (idx == 3'd0)) begin
                        dir        <= DIR_LEFT;
                        bounce_cnt <= bounce_cnt + 1'b1;
                     end
                  end else begin
                     // Clearing led_q lets a held bad sample re-seed acquisition.
                     err_pulse <= 1'b1;
                     if (err_cnt != '1) err_cnt <= err_cnt + 1'b1;
                     locked    <= 1'b0;
                     led_q     <= '0;
                     state     <= IDLE;
                  end
               end
               default: begin
                  led_q <= '0;
                  state <= IDLE;
               end
            endcase
         end
      end
   end

endmodule : led_sweep_decoder
